// File: rtl/instr_mem_loader.sv
// instr_mem_loader: filters a framed byte stream by node ID and writes little-endian words into instruction RAM
module instr_mem_loader #(
  parameter int SIZE    = 128,
  parameter int NODE_ID = 0,
  parameter int AW      = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [31:0]   wdata,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err
);
  typedef enum logic [2:0] {HDR, CNT_LO, CNT_HI, DATA, DONE} state_t;
  state_t state_q, state_d;
  logic match_q, match_d, hold_q, hold_d, err_q, err_d, we_q, we_d;
  logic [15:0] cnt_q, cnt_d, word_q, word_d;
  logic [1:0] byte_q, byte_d;
  logic [23:0] asm_q, asm_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic acc, in_range;
  assign in_ready  = state_q != DONE;
  assign acc       = in_valid && in_ready;
  assign in_range  = 32'(word_q) < SIZE;
  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign cpu_hold  = hold_q;
  assign load_err  = err_q;
  assign load_done = state_q == DONE && match_q;
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    hold_d  = hold_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    byte_d  = byte_q;
    asm_d   = asm_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    case (state_q)
      HDR: if (acc) begin
        match_d = in_data == 8'(NODE_ID) || in_data == 8'hFF;
        hold_d  = match_d;
        err_d   = 1'b0;
        state_d = CNT_LO;
      end
      CNT_LO: if (acc) begin
        cnt_d[7:0] = in_data;
        state_d    = CNT_HI;
      end
      CNT_HI: if (acc) begin
        cnt_d[15:8] = in_data;
        word_d      = '0;
        byte_d      = '0;
        state_d     = cnt_d == 16'd0 ? DONE : DATA;
      end
      DATA: if (acc) begin
        // bytes arrive LSB first, so shifting in from the top leaves them in order
        asm_d  = {in_data, asm_q[23:8]};
        byte_d = byte_q + 2'd1;
        if (byte_q == 2'd3) begin
          we_d    = match_q && in_range;
          err_d   = err_q || (match_q && !in_range);
          waddr_d = word_q[AW-1:0];
          wdata_d = {in_data, asm_q};
          word_d  = word_q + 16'd1;
          state_d = word_q == cnt_q - 16'd1 ? DONE : DATA;
        end
      end
      default: begin
        hold_d  = 1'b0;
        state_d = HDR;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HDR;
      match_q <= 1'b0;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      word_q  <= '0;
      byte_q  <= '0;
      asm_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      asm_q   <= asm_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: two loaders (node 1 with a 4-word RAM, node 3 with 128 words) share one byte stream
module tb_instr_mem_loader;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic rdy_a, we_a, hold_a, done_a, err_a, rdy_b, we_b, hold_b, done_b, err_b;
  logic [1:0] waddr_a;
  logic [6:0] waddr_b;
  logic [31:0] wdata_a, wdata_b;
  int checks = 0, failures = 0;
  int nid[2] = '{1, 3};
  int sz[2] = '{4, 128};
  int pos[2], n[2], e_waddr[2], done_cnt[2], k, w;
  bit m[2], e_we[2], e_hold[2], e_done[2], e_err[2];
  bit e_ready[2] = '{1, 1};
  logic [31:0] e_wdata[2];
  logic [7:0] bt[2][4];
  int qa_a[$], qa_b[$];
  logic [31:0] qd_a[$], qd_b[$];
  logic [7:0] fr[$];

  always #5 clk = ~clk;

  instr_mem_loader #(.SIZE(4), .NODE_ID(1), .AW(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
    .we(we_a), .waddr(waddr_a), .wdata(wdata_a), .cpu_hold(hold_a), .load_done(done_a), .load_err(err_a));
  instr_mem_loader #(.SIZE(128), .NODE_ID(3), .AW(7)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
    .we(we_b), .waddr(waddr_b), .wdata(wdata_b), .cpu_hold(hold_b), .load_done(done_b), .load_err(err_b));

  // Frame model: reasons about byte position within the frame, not about loader states
  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        pos[d] = 0; e_ready[d] = 1; e_we[d] = 0; e_hold[d] = 0; e_done[d] = 0; e_err[d] = 0;
      end else begin
        e_we[d] = 0;
        e_done[d] = 0;
        if (!e_ready[d]) begin
          e_ready[d] = 1;
          e_hold[d] = 0;
        end else if (in_valid) begin
          if (pos[d] == 0) begin
            m[d] = in_data == nid[d] || in_data == 8'hFF;
            e_hold[d] = m[d];
            e_err[d] = 0;
          end else if (pos[d] == 1) n[d] = in_data;
          else if (pos[d] == 2) n[d] += 256 * in_data;
          else begin
            k = (pos[d] - 3) % 4;
            bt[d][k] = in_data;
            if (k == 3) begin
              w = (pos[d] - 3) / 4;
              if (m[d] && w < sz[d]) begin
                e_we[d] = 1;
                e_waddr[d] = w;
                e_wdata[d] = {bt[d][3], bt[d][2], bt[d][1], bt[d][0]};
              end else if (m[d]) e_err[d] = 1;
            end
          end
          if (pos[d] >= 2 && pos[d] == 2 + 4 * n[d]) begin
            e_ready[d] = 0;
            e_done[d] = m[d];
            pos[d] = 0;
          end else pos[d]++;
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  task automatic chk(input int d, input logic rdy, input logic we, input logic [6:0] wa,
                     input logic [31:0] wd, input logic hold, input logic done, input logic err);
    cmp($sformatf("d%0d_in_ready", d), 32'(rdy), 32'(e_ready[d]));
    cmp($sformatf("d%0d_we", d), 32'(we), 32'(e_we[d]));
    cmp($sformatf("d%0d_cpu_hold", d), 32'(hold), 32'(e_hold[d]));
    cmp($sformatf("d%0d_load_done", d), 32'(done), 32'(e_done[d]));
    cmp($sformatf("d%0d_load_err", d), 32'(err), 32'(e_err[d]));
    if (e_we[d]) begin
      cmp($sformatf("d%0d_waddr", d), 32'(wa), 32'(e_waddr[d]));
      cmp($sformatf("d%0d_wdata", d), wd, e_wdata[d]);
    end
  endtask

  always @(negedge clk) begin
    chk(0, rdy_a, we_a, {5'd0, waddr_a}, wdata_a, hold_a, done_a, err_a);
    chk(1, rdy_b, we_b, waddr_b, wdata_b, hold_b, done_b, err_b);
    if (we_a) begin qa_a.push_back(int'(waddr_a)); qd_a.push_back(wdata_a); end
    if (we_b) begin qa_b.push_back(int'(waddr_b)); qd_b.push_back(wdata_b); end
    if (done_a) done_cnt[0]++;
    if (done_b) done_cnt[1]++;
  end

  task automatic clear_logs();
    qa_a.delete(); qd_a.delete(); qa_b.delete(); qd_b.delete();
    done_cnt[0] = 0; done_cnt[1] = 0;
  endtask

  task automatic send(input int maxgap);
    foreach (fr[i]) begin
      repeat ($urandom_range(maxgap, 0)) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data = fr[i];
      for (int t = 0; !e_ready[0]; t++) begin
        if (t > 4) begin
          checks++;
          failures++;
          $display("FAIL ready_timeout t=%0t", $time);
          break;
        end
        @(negedge clk);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    fr = '{8'h01, 8'h02, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00, 8'hB3, 8'h82, 8'h52, 8'h00};
    send(0);
    cmp("basic_nwrites", qa_a.size(), 2);
    cmp("basic_addr0", qa_a[0], 0);
    cmp("basic_data0", qd_a[0], 32'h00500293);
    cmp("basic_addr1", qa_a[1], 1);
    cmp("basic_data1", qd_a[1], 32'h005282B3);
    cmp("basic_done", done_cnt[0], 1);
    cmp("foreign_nwrites", qa_b.size(), 0);
    cmp("foreign_done", done_cnt[1], 0);
    clear_logs();
    fr = '{8'h02, 8'h01, 8'h00, 8'h63, 8'h00, 8'h00, 8'h00};
    send(0);
    cmp("foreign2_nwrites", qa_a.size(), 0);
    cmp("foreign2_done", done_cnt[0], 0);
    fr = '{8'h01, 8'h01, 8'h00, 8'h63, 8'h00, 8'h00, 8'h00};
    send(0);
    cmp("after_foreign_nwrites", qa_a.size(), 1);
    cmp("after_foreign_data", qd_a[0], 32'h00000063);
    clear_logs();
    fr = '{8'hFF, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    send(0);
    cmp("bcast_nwrites", qa_b.size(), 1);
    cmp("bcast_addr", qa_b[0], 0);
    cmp("bcast_data", qd_b[0], 32'h00000013);
    cmp("bcast_done", done_cnt[1], 1);
    clear_logs();
    fr = '{8'hFF, 8'h05, 8'h00};
    for (int i = 1; i <= 5; i++) fr = {fr, 8'(i), 8'h00, 8'h00, 8'h00};
    send(0);
    cmp("ovf_nwrites", qa_a.size(), 4);
    cmp("ovf_last_addr", qa_a[3], 3);
    cmp("ovf_last_data", qd_a[3], 32'h4);
    cmp("ovf_err", 32'(err_a), 1);
    cmp("ovf_done", done_cnt[0], 1);
    cmp("big_nwrites", qa_b.size(), 5);
    cmp("big_addr4", qa_b[4], 4);
    cmp("big_err", 32'(err_b), 0);
    clear_logs();
    fr = '{8'h03, 8'h00, 8'h00};
    send(0);
    cmp("zero_err_cleared", 32'(err_a), 0);
    cmp("zero_done_b", done_cnt[1], 1);
    cmp("zero_done_a", done_cnt[0], 0);
    cmp("zero_nwrites", qa_b.size(), 0);
    clear_logs();
    fr = '{8'h03, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01};
    send(0);
    send(3);
    cmp("stall_nwrites", qa_b.size(), 4);
    cmp("stall_data0", qd_b[0], 32'hDEADBEEF);
    cmp("stall_data2", qd_b[2], 32'hDEADBEEF);
    cmp("stall_addr3", qa_b[3], 1);
    cmp("stall_data3", qd_b[3], 32'h01234567);
    clear_logs();
    fr = '{8'hFF, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send(0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    cmp("rst_hold", 32'(hold_a), 0);
    cmp("rst_we", 32'(we_a), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    fr = '{8'hFF, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    send(0);
    cmp("post_rst_nwrites", qa_a.size(), 1);
    cmp("post_rst_addr", qa_a[0], 0);
    cmp("post_rst_data", qd_a[0], 32'h11223344);
    cmp("post_rst_done", done_cnt[0], 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Runtime writer for a node's instruction memory: receives a byte stream, filters it by node ID, and assembles 32-bit little-endian words.
- Drives a word-addressed write port into the node's instruction RAM and holds the node's core in reset while loading.
- One instance per node; loads program images without resynthesis.

Parameters:
- SIZE, 128, instruction memory depth in 32-bit words
- NODE_ID, 0, node identifier matched against the frame header byte
- AW, 7, write address width; must satisfy 2**AW >= SIZE

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  byte stream valid
- in_ready  output  1  byte stream ready; a byte is accepted when in_valid && in_ready
- in_data  input  8  stream byte
- we  output  1  instruction RAM write enable, one-cycle pulse per word
- waddr  output  AW  word address for the write
- wdata  output  32  word data for the write
- cpu_hold  output  1  holds the node core in reset while this node's frame loads
- load_done  output  1  one-cycle pulse at frame end
- load_err  output  1  sticky overflow flag; cleared at next accepted header

Behaviour:
- Reset values (async, rst_n=0): state=HDR; we, cpu_hold, load_done, load_err = 0; waddr, wdata, word counter, byte counter = 0.
- Frame format:
  - byte 0: target ID (0xFF = broadcast)
  - bytes 1-2: word count N, 16-bit little-endian
  - then 4*N data bytes, each word LSB first
- in_ready = 1 in every state except DONE.
- State HDR: on accept, match = (in_data==NODE_ID || in_data==0xFF). Set cpu_hold = match, clear load_err, go to CNT_LO.
- State CNT_LO: on accept, latch N[7:0], go to CNT_HI.
- State CNT_HI: on accept, latch N[15:8]. If N==0, go to DONE; else go to DATA with word index 0 and byte index 0.
- State DATA:
  - Each accept shifts the byte into position byte_idx*8 of the assembly register.
  - On the 4th byte: the next cycle drives we = match && (word_idx < SIZE), waddr = word_idx[AW-1:0], wdata = assembled word.
  - Increment word_idx. When word_idx reaches N-1 on its 4th byte, go to DONE.
  - Latency: we is asserted exactly 1 cycle after the 4th byte is accepted.
- Overflow: if match and word_idx >= SIZE, no write occurs and load_err is set. Remaining bytes are still consumed so framing stays aligned.
- Non-matching frame: all bytes are consumed, we is never asserted, cpu_hold stays 0.
- State DONE (1 cycle): pulse load_done only if match, clear cpu_hold, go to HDR. in_ready=0 in this cycle.
- Stall handling: when in_valid=0, state and counters hold. Gaps between bytes of any length are legal.
- The last write and the DONE cycle coincide: we and load_done may be high in the same cycle.
- Reset mid-frame returns to HDR immediately and drops cpu_hold. The partial word is discarded and no we is issued.
- word_idx is 16 bits wide and never wraps within a frame (N <= 65535). waddr is the truncated low AW bits, used only when word_idx < SIZE.

Test Plan:
- Basic load, NODE_ID=1: send 01 02 00 93 02 50 00 B3 82 52 00 -> we at waddr 0 with wdata 0x00500293, then waddr 1 with 0x005282B3; cpu_hold high from the cycle after the header to DONE; one load_done pulse.
- Foreign frame, NODE_ID=1: send 02 01 00 63 00 00 00 -> no we, cpu_hold=0, load_done=0; the next frame 01 01 00 63 00 00 00 writes 0x00000063 to waddr 0.
- Broadcast: send FF 01 00 13 00 00 00 to NODE_ID=3 -> we at waddr 0 with wdata 0x00000013, then load_done.
- Overflow, SIZE=4: header 00 05 00 followed by 5 words -> we pulses for addresses 0..3 only; load_err=1 after the 5th word; load_done pulses. The next header clears load_err.
- Zero count and stalls: 00 00 00 -> load_done 1 cycle after CNT_HI with no we. Random in_valid gaps during a 2-word frame give identical writes.
- Reset mid-frame: deassert rst_n after 2 data bytes -> all outputs 0 and no we. A full frame afterwards loads correctly from waddr 0.
